// File: rtl/vga_scanout.sv
// VGA scan-out engine: pixel divider, h/v counters, linear VRAM addressing, registered RGB/sync.
// Optional SCANOUT_TEST_PATTERN_EN adds a test_pattern input that selects eight colour bars.
module vga_scanout #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic [18:0] vram_addr,
  input  logic [11:0] vram_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        vblank,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT      = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   H_ACT_LAST = H_W'(H_ACTIVE - 1);
  localparam logic [H_W-1:0]   HS_BEG     = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_END     = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACT      = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   V_ACT_LAST = V_W'(V_ACTIVE - 1);
  localparam logic [V_W-1:0]   VS_BEG     = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_END     = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [H_W-1:0]   hcnt;
  logic [V_W-1:0]   vcnt;
  logic             pix_tick;
  logic             active;
  logic             last_pixel;
  logic             frame_wrap;
  logic             hs_raw;
  logic             vs_raw;
  logic [11:0]      pix_color;

  assign pix_tick = (div == DIV_LAST);

  always_comb begin
    active     = (hcnt < H_ACT) && (vcnt < V_ACT);
    last_pixel = (hcnt == H_ACT_LAST) && (vcnt == V_ACT_LAST);
    frame_wrap = (hcnt == H_LAST) && (vcnt == V_LAST);
    hs_raw     = !((hcnt >= HS_BEG) && (hcnt < HS_END));
    vs_raw     = !((vcnt >= VS_BEG) && (vcnt < VS_END));
  end

`ifdef SCANOUT_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  logic [2:0] bar;

  // Bar index picks R/G/B bits directly: white,yellow,cyan,green,magenta,red,blue,black.
  always_comb begin
    bar = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (hcnt >= H_W'(i * BAR_W)) bar = 3'(i);
    end
    if (test_pattern) pix_color = {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}};
    else              pix_color = vram_data;
  end
`else
  always_comb begin
    pix_color = vram_data;
  end
`endif

  // The address is held at the last active pixel through vblank so it never exceeds the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= '0;
      hcnt      <= '0;
      vcnt      <= '0;
      vram_addr <= '0;
    end else begin
      div <= pix_tick ? '0 : div + DIV_W'(1);
      if (pix_tick) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + V_W'(1);
        end else begin
          hcnt <= hcnt + H_W'(1);
        end
        if (frame_wrap)                vram_addr <= '0;
        else if (active && !last_pixel) vram_addr <= vram_addr + 19'd1;
      end
    end
  end

  // Data for the addressed pixel is sampled at the end of its address period and shown for the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {vga_r, vga_g, vga_b} <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_tick) begin
        {vga_r, vga_g, vga_b} <= active ? pix_color : '0;
        hsync       <= hs_raw;
        vsync       <= vs_raw;
        vblank      <= (vcnt >= V_ACT);
        frame_start <= (hcnt == '0) && (vcnt == V_ACT);
      end
    end
  end

endmodule
